// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the write-side handshake state encoding for the
// scancode FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_OVERRUN_CODE = 8'h00;
    localparam logic [7:0] PS2_BREAK_CODE   = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE     = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        WAITLO = 2'd2
    } wr_state_t;

endpackage

// File: rtl/ps2_fifo_mem.sv
// DEPTH x 8 scancode storage: synchronous write port, asynchronous read port.
// No reset; contents are qualified by the FIFO occupancy count.
module ps2_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ps2_code_fifo.sv
// Scancode FIFO between the PS/2 receiver and the PS/2-to-MSX decode FSM.
// Optional PS2_OVERRUN_MARK_EN: reserve the last slot for an 8'h00 overrun code.
module ps2_code_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    in_code,
    input  logic          in_rdy,
    output logic          in_clr,
    output logic [7:0]    out_code,
    output logic          out_rdy,
    input  logic          out_clr,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr
);

    wr_state_t   state_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          out_clr_q_r;
    logic          in_clr_r;
    logic          overflow_r;

    logic          capture_s;
    logic          pop_req_s;
    logic          do_pop_s;
    logic          do_push_s;
    logic          ovf_set_s;
    logic [7:0]    push_data_s;
    logic [AW:0]   eff_count_s;
    logic [7:0]    rdata_s;

    // Push/pop decision; a pop in the same cycle frees a slot before the push is judged
    always_comb begin
        capture_s   = (state_r == IDLE) && in_rdy;
        pop_req_s   = out_clr && !out_clr_q_r;
        do_pop_s    = pop_req_s && (count_r != '0);
        eff_count_s = count_r - (AW+1)'(do_pop_s);
        do_push_s   = 1'b0;
        ovf_set_s   = 1'b0;
        push_data_s = in_code;
`ifdef PS2_OVERRUN_MARK_EN
        if (capture_s && (eff_count_s == (AW+1)'(DEPTH - 1))) begin
            do_push_s   = 1'b1;
            ovf_set_s   = 1'b1;
            push_data_s = PS2_OVERRUN_CODE;
        end else if (capture_s && (eff_count_s < (AW+1)'(DEPTH - 1))) begin
            do_push_s   = 1'b1;
            ovf_set_s   = 1'b0;
            push_data_s = in_code;
        end else begin
            do_push_s   = 1'b0;
            ovf_set_s   = capture_s;
            push_data_s = in_code;
        end
`else
        if (capture_s && (eff_count_s < (AW+1)'(DEPTH))) begin
            do_push_s = 1'b1;
            ovf_set_s = 1'b0;
        end else begin
            do_push_s = 1'b0;
            ovf_set_s = capture_s;
        end
`endif
    end

    // Write handshake FSM, pointers, occupancy and sticky overflow
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_clr_q_r <= 1'b0;
            in_clr_r    <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            out_clr_q_r <= out_clr;
            case (state_r)
                IDLE: begin
                    in_clr_r <= capture_s;
                    state_r  <= capture_s ? ACK : IDLE;
                end
                ACK: begin
                    in_clr_r <= 1'b0;
                    state_r  <= WAITLO;
                end
                WAITLO: begin
                    in_clr_r <= 1'b0;
                    state_r  <= in_rdy ? WAITLO : IDLE;
                end
                default: begin
                    in_clr_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    ps2_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (do_push_s),
        .waddr (wr_ptr_r),
        .wdata (push_data_s),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    assign in_clr   = in_clr_r;
    assign overflow = overflow_r;
    assign level    = count_r;
    assign out_rdy  = (count_r != '0);
    assign out_code = (count_r != '0) ? rdata_s : 8'h00;

endmodule

// File: tb/tb_ps2_code_fifo.sv
// Directed self-checking bench for ps2_code_fifo (DEPTH = 8); follows
// PS2_OVERRUN_MARK_EN when it is defined for the build.
module tb_ps2_code_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] in_code = 8'h00;
    logic       in_rdy = 1'b0;
    logic       in_clr;
    logic [7:0] out_code;
    logic       out_rdy;
    logic       out_clr = 1'b0;
    logic [3:0] level;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int clr_cnt = 0;
    int c0;

    ps2_code_fifo #(.DEPTH(8), .AW(3)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_code  (in_code),
        .in_rdy   (in_rdy),
        .in_clr   (in_clr),
        .out_code (out_code),
        .out_rdy  (out_rdy),
        .out_clr  (out_clr),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 CLK = ~CLK;

    // in_clr is a one-cycle pulse, so one sample per cycle counts each pulse once
    always @(negedge CLK) begin
        if (in_clr) clr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        in_code = b;
        in_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!in_clr && n < 20);
        check("ack_seen", {31'd0, in_clr}, 32'd1);
        in_rdy = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic pop_one();
        out_clr = 1'b1;
        @(negedge CLK);
        out_clr = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_in_clr",   {31'd0, in_clr},   32'd0);
        check("rst_out_rdy",  {31'd0, out_rdy},  32'd0);
        check("rst_out_code", {24'd0, out_code}, 32'h00);
        check("rst_level",    {28'd0, level},    32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Single byte
        c0 = clr_cnt;
        in_code = 8'h1C;
        in_rdy  = 1'b1;
        @(negedge CLK);
        check("single_in_clr_hi", {31'd0, in_clr},   32'd1);
        check("single_out_rdy",   {31'd0, out_rdy},  32'd1);
        check("single_out_code",  {24'd0, out_code}, 32'h1C);
        check("single_level",     {28'd0, level},    32'd1);
        in_rdy = 1'b0;
        @(negedge CLK);
        check("single_in_clr_lo", {31'd0, in_clr}, 32'd0);
        @(negedge CLK);
        check("single_clr_pulses", clr_cnt - c0, 32'd1);
        pop_one();
        check("single_pop_rdy",   {31'd0, out_rdy}, 32'd0);
        check("single_pop_level", {28'd0, level},   32'd0);

        // Burst order with the consumer stalled
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("burst_level", {28'd0, level}, 32'd3);
        check("burst_0", {24'd0, out_code}, 32'hE0);
        pop_one();
        check("burst_1", {24'd0, out_code}, 32'hF0);
        pop_one();
        check("burst_2", {24'd0, out_code}, 32'h75);
        pop_one();
        check("burst_empty", {31'd0, out_rdy}, 32'd0);

        // Held ready and held consume
        c0 = clr_cnt;
        in_code = 8'h33;
        in_rdy  = 1'b1;
        repeat (20) @(negedge CLK);
        check("held_level", {28'd0, level}, 32'd1);
        check("held_clr_pulses", clr_cnt - c0, 32'd1);
        in_rdy = 1'b0;
        repeat (2) @(negedge CLK);
        send_byte(8'h44);
        out_clr = 1'b1;
        repeat (10) @(negedge CLK);
        check("held_pop_level", {28'd0, level}, 32'd1);
        check("held_pop_code", {24'd0, out_code}, 32'h44);
        out_clr = 1'b0;
        @(negedge CLK);
        pop_one();
        check("held_drained", {28'd0, level}, 32'd0);

`ifdef PS2_OVERRUN_MARK_EN
        // Overrun mark: 7 data bytes, then 8'h00, then a drop
        for (int i = 0; i < 9; i++) send_byte(8'h20 + 8'(i));
        check("mark_level",    {28'd0, level},    32'd8);
        check("mark_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            check("mark_data", {24'd0, out_code}, 32'h20 + 32'(i));
            pop_one();
        end
        check("mark_code", {24'd0, out_code}, 32'h00);
        check("mark_rdy",  {31'd0, out_rdy},  32'd1);
        pop_one();
        check("mark_empty", {28'd0, level}, 32'd0);
`else
        // Full, then simultaneous push and pop, then a real drop
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        check("full_level", {28'd0, level}, 32'd8);
        in_code = 8'h18;
        in_rdy  = 1'b1;
        out_clr = 1'b1;
        @(negedge CLK);
        check("simul_level",    {28'd0, level},    32'd8);
        check("simul_overflow", {31'd0, overflow}, 32'd0);
        check("simul_in_clr",   {31'd0, in_clr},   32'd1);
        check("simul_head",     {24'd0, out_code}, 32'h11);
        out_clr = 1'b0;
        in_rdy  = 1'b0;
        repeat (2) @(negedge CLK);
        c0 = clr_cnt;
        send_byte(8'h19);
        check("drop_overflow", {31'd0, overflow}, 32'd1);
        check("drop_level",    {28'd0, level},    32'd8);
        check("drop_clr_pulse", clr_cnt - c0, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", {24'd0, out_code}, 32'h11 + 32'(i));
            pop_one();
        end
        check("drain_empty", {28'd0, level}, 32'd0);
        check("drain_code",  {24'd0, out_code}, 32'h00);
`endif
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge CLK);
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Reset mid-handshake with three entries queued
        send_byte(8'hA1);
        send_byte(8'hA2);
        in_code = 8'hA3;
        in_rdy  = 1'b1;
        @(negedge CLK);
        check("pre_rst_in_clr", {31'd0, in_clr}, 32'd1);
        check("pre_rst_level",  {28'd0, level},  32'd3);
        in_code = 8'h5A;
        #2;
        RST = 1'b0;
        #1;
        check("async_in_clr",   {31'd0, in_clr},   32'd0);
        check("async_out_rdy",  {31'd0, out_rdy},  32'd0);
        check("async_out_code", {24'd0, out_code}, 32'h00);
        check("async_level",    {28'd0, level},    32'd0);
        @(negedge CLK);
        c0 = clr_cnt;
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        check("post_rst_level", {28'd0, level},    32'd1);
        check("post_rst_code",  {24'd0, out_code}, 32'h5A);
        check("post_rst_pulse", clr_cnt - c0,      32'd1);
        in_rdy = 1'b0;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
